// File: rtl/collect_nonce_pkg.sv
// collect_nonce_pkg: shared cryptonight constants for the nonce collector
package collect_nonce_pkg;
  localparam int CMP_WIDTH = 64;
  localparam int DEF_INPUT_COUNT = 8;
  localparam int DEF_HASH_WIDTH = 256;
  localparam int DEF_NONCE_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic logic meets_target(input logic [CMP_WIDTH-1:0] value, input logic [CMP_WIDTH-1:0] tgt);
    return value < tgt;
  endfunction
endpackage

// File: rtl/collect_nonce_if.sv
// collect_nonce_if: hash-result input and found-nonce output handshakes
interface collect_nonce_if
  import collect_nonce_pkg::*;
#(
  parameter int HASH_WIDTH = DEF_HASH_WIDTH,
  parameter int NONCE_WIDTH = DEF_NONCE_WIDTH
) ();
  logic [HASH_WIDTH-1:0] output_data;
  logic output_data_valid;
  logic output_data_ready;
  logic [NONCE_WIDTH-1:0] found_nonce;
  logic found_valid;
  logic found_ready;
  modport master (
    output output_data, output_data_valid, found_ready,
    input output_data_ready, found_nonce, found_valid
  );
  modport slave (
    input output_data, output_data_valid, found_ready,
    output output_data_ready, found_nonce, found_valid
  );
endinterface

// File: rtl/collect_nonce_fifo.sv
// nonce_fifo: synchronous found-nonce buffer with registered pointers and occupancy count
module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic [WIDTH-1:0] din,
  input logic pop,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/collect_nonce.sv
// collect_nonce: tags each hash result with its nonce and buffers those meeting the target
module collect_nonce
  import collect_nonce_pkg::*;
#(
  parameter int INPUT_COUNT = DEF_INPUT_COUNT,
  parameter int HASH_WIDTH = DEF_HASH_WIDTH,
  parameter int NONCE_WIDTH = DEF_NONCE_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic output_data_aclk,
  input logic output_data_rst_n,
  collect_nonce_if.slave bus,
  input logic [NONCE_WIDTH-1:0] base_nonce,
  input logic [CMP_WIDTH-1:0] target,
  output logic [NONCE_WIDTH-1:0] match_count,
  output logic done
);
  logic [NONCE_WIDTH-1:0] index, fifo_dout;
  logic fifo_empty, fifo_full, xfer, hit, pop;
  logic unused_low_bits;
  assign unused_low_bits = ^bus.output_data[HASH_WIDTH-CMP_WIDTH-1:0];
  // ready depends only on registers, so a match can always be pushed
  assign bus.output_data_ready = output_data_rst_n & ~done & ~fifo_full;
  assign xfer = bus.output_data_valid & bus.output_data_ready;
  assign hit = xfer & meets_target(bus.output_data[HASH_WIDTH-1 -: CMP_WIDTH], target);
  assign bus.found_valid = output_data_rst_n & ~fifo_empty;
  assign bus.found_nonce = bus.found_valid ? fifo_dout : '0;
  assign pop = bus.found_valid & bus.found_ready;
  always_ff @(posedge output_data_aclk) begin
    if (!output_data_rst_n) begin
      index <= '0;
      match_count <= '0;
      done <= 1'b0;
    end else if (xfer) begin
      index <= index + NONCE_WIDTH'(1);
      match_count <= match_count + NONCE_WIDTH'(hit);
      done <= index == NONCE_WIDTH'(INPUT_COUNT - 1);
    end
  end
  nonce_fifo #(.WIDTH(NONCE_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(output_data_aclk),
    .rst_n(output_data_rst_n),
    .push(hit),
    .din(base_nonce + index),
    .pop(pop),
    .dout(fifo_dout),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_collect_nonce.sv
// tb_collect_nonce: randomized scoreboard bench for collect_nonce
module tb_collect_nonce;
  localparam int N = 8;
  logic clk = 0, rst_n = 0;
  logic [31:0] base_nonce = 0, match_count;
  logic [63:0] target = 0;
  logic done;
  collect_nonce_if #(.HASH_WIDTH(256), .NONCE_WIDTH(32)) hif ();
  collect_nonce #(.INPUT_COUNT(N), .HASH_WIDTH(256), .NONCE_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .output_data_aclk(clk), .output_data_rst_n(rst_n), .bus(hif),
    .base_nonce(base_nonce), .target(target), .match_count(match_count), .done(done)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0, exp_cnt = 0, rdy_mode = 1;
  logic [31:0] exp_q[$];
  logic [63:0] fields [N];
  logic prev_stall = 0;
  logic [31:0] prev_nonce = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    hif.found_ready = 1;
    forever begin
      @(posedge clk);
      #1 hif.found_ready = rdy_mode == 2 ? 1'($urandom % 2) : rdy_mode == 1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall && hif.found_valid) chk("found_nonce stable", hif.found_nonce, prev_nonce);
      if (hif.found_valid && hif.found_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected found_nonce: got %0h expected none", hif.found_nonce);
        end else chk("found_nonce", hif.found_nonce, exp_q.pop_front());
      end
      prev_stall = hif.found_valid & ~hif.found_ready;
      prev_nonce = hif.found_nonce;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic send_hash(input int i, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom % 3) @(negedge clk);
    @(negedge clk);
    for (int w = 0; w < 6; w++) hif.output_data[32*w +: 32] = $urandom;
    hif.output_data[255:192] = fields[i];
    hif.output_data_valid = 1;
    while (!hif.output_data_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("ready timeout", t < 300, 1);
    if (fields[i] < target) begin
      exp_q.push_back(base_nonce + 32'(i));
      exp_cnt++;
    end
    @(posedge clk);
    #1 hif.output_data_valid = 0;
  endtask
  task automatic do_reset(input bit check);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("reset found_valid", hif.found_valid, 0);
      chk("reset ready", hif.output_data_ready, 0);
      chk("reset match_count", match_count, 0);
      chk("reset done", done, 0);
      chk("reset found_nonce", hif.found_nonce, 0);
    end
    exp_q.delete();
    exp_cnt = 0;
    rst_n = 1;
  endtask
  task automatic drain_check();
    int t = 0;
    while ((exp_q.size() != 0 || hif.found_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain timeout", t < 500, 1);
    chk("done", done, 1);
    chk("match_count", match_count, 64'(exp_cnt));
    chk("ready after done", hif.output_data_ready, 0);
  endtask
  task automatic all_match();
    target = '1;
    for (int i = 0; i < N; i++) fields[i] = {1'b0, 31'($urandom), 32'($urandom)};
  endtask
  initial begin
    hif.output_data = '0;
    hif.output_data_valid = 0;
    do_reset(1);
    // all results match, nonces come out in order
    base_nonce = 32'h100;
    all_match();
    rdy_mode = 1;
    for (int i = 0; i < N; i++) begin
      send_hash(i, 0);
      if (i == N - 2) begin
        @(negedge clk);
        chk("done early", done, 0);
      end
    end
    drain_check();
    // single match at index 3, one-cycle latency
    do_reset(0);
    base_nonce = 32'h2000;
    target = 64'h10;
    for (int i = 0; i < N; i++) fields[i] = (i == 3) ? 64'h0F : 64'h10;
    for (int i = 0; i < N; i++) begin
      send_hash(i, 0);
      if (i == 3) begin
        @(negedge clk);
        chk("latency found_valid", hif.found_valid, 1);
        chk("latency found_nonce", hif.found_nonce, 32'h2003);
      end
    end
    drain_check();
    chk("single match_count", match_count, 1);
    // back-pressure: FIFO fills, ready drops, then resumes
    do_reset(0);
    base_nonce = 32'h3000;
    all_match();
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) send_hash(i, 0);
    @(negedge clk);
    chk("ready when full", hif.output_data_ready, 0);
    chk("found_valid when full", hif.found_valid, 1);
    rdy_mode = 1;
    for (int i = 4; i < N; i++) send_hash(i, 0);
    drain_check();
    // nonce wrap-around
    do_reset(0);
    base_nonce = 32'hFFFF_FFFE;
    all_match();
    rdy_mode = 2;
    for (int i = 0; i < N; i++) send_hash(i, 1);
    drain_check();
    // reset mid-job with two nonces buffered
    do_reset(0);
    base_nonce = 32'h500;
    all_match();
    fields[1] = '1;
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send_hash(i, 0);
    @(negedge clk);
    chk("buffered before reset", match_count, 2);
    do_reset(1);
    rdy_mode = 1;
    all_match();
    for (int i = 0; i < N; i++) send_hash(i, 0);
    drain_check();
    // randomized jobs near the target, including target 0
    for (int j = 0; j < 20; j++) begin
      do_reset(0);
      base_nonce = $urandom;
      target = (j == 5) ? 64'h0 : {32'($urandom), 32'($urandom)};
      for (int i = 0; i < N; i++) fields[i] = target + 64'($signed(32'($urandom_range(0, 8)) - 32'sd4));
      rdy_mode = 2;
      for (int i = 0; i < N; i++) send_hash(i, 1);
      drain_check();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/collect_nonce.md
COLLECT_NONCE -- requirements
Module: collect_nonce

Interface
REQ-001 SHALL have parameter INPUT_COUNT, default 8, number of hash results expected per job.
REQ-002 SHALL have parameter HASH_WIDTH, default 256, width of one hash result.
REQ-003 SHALL have parameter NONCE_WIDTH, default 32, nonce width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, depth of the found-nonce buffer (power of two, at least 2).
REQ-005 SHALL have port output_data_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port output_data_rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port output_data  in  HASH_WIDTH  hash result; byte k on bits [8k+7:8k].
REQ-008 SHALL have port output_data_valid  in  1  hash result valid.
REQ-009 SHALL have port output_data_ready  out  1  hash result accepted when high with valid.
REQ-010 SHALL have port base_nonce  in  NONCE_WIDTH  nonce of result index 0; stable for the whole job.
REQ-011 SHALL have port target  in  64  difficulty target; stable for the whole job.
REQ-012 SHALL have port found_nonce  out  NONCE_WIDTH  nonce of a hash that met the target.
REQ-013 SHALL have port found_valid  out  1  found_nonce valid.
REQ-014 SHALL have port found_ready  in  1  downstream consumes found_nonce.
REQ-015 SHALL have port match_count  out  NONCE_WIDTH  number of hashes that met the target this job.
REQ-016 SHALL have port done  out  1  all INPUT_COUNT results received.

Function
REQ-017 SHALL define transfer-in as output_data_valid and output_data_ready both high on a rising edge.
REQ-018 SHALL keep an index counter, 0 at reset, incremented by 1 per transfer-in (NONCE_WIDTH bits).
REQ-019 SHALL tag each transfer-in with nonce = base_nonce + index, computed modulo 2^NONCE_WIDTH with wrap-around and no error.
REQ-020 SHALL take the compare value as output_data[HASH_WIDTH-1:HASH_WIDTH-64], read as a 64-bit unsigned value with byte 24 as least significant.
REQ-021 SHALL declare a match when compare value < target (unsigned, strict); target 0 never matches.
REQ-022 SHALL push the tagged nonce of a matching transfer-in into the FIFO and increment match_count in the same edge.
REQ-023 SHALL drive output_data_ready = ~done & ~fifo_full, combinationally from registered state only, so no match is ever dropped.
REQ-024 SHALL drive found_valid = ~fifo_empty, with found_nonce the FIFO head; a pop occurs on found_valid & found_ready.
REQ-025 SHALL make a nonce pushed at edge N visible on found_valid/found_nonce after edge N when the FIFO was empty (latency 1 cycle).
REQ-026 SHALL on simultaneous push and pop leave the occupancy unchanged; the FIFO is never full at a push because of REQ-023.
REQ-027 SHALL keep found_nonce stable while found_valid is high and found_ready is low.
REQ-028 SHALL assert done registered on the edge of the INPUT_COUNT-th transfer-in; done is sticky until reset; no transfer-in occurs while done.
REQ-029 SHALL keep draining the FIFO after done until it is empty.

Reset
REQ-030 SHALL on output_data_rst_n low at an edge clear index, match_count, done and FIFO pointers; found_valid 0, output_data_ready 0 during reset, found_nonce 0.
REQ-031 SHALL on reset mid-job discard buffered nonces and restart a new job from index 0.

Structure
REQ-032 SHALL take the compare field position (64-bit, top of hash) and default widths from the shared cryptonight constants package.
REQ-033 SHALL implement the buffer as one sub-module nonce_fifo (synchronous, registered pointers, occupancy count).

Verification
REQ-034 SHALL cover: INPUT_COUNT=8, base_nonce=0x100, target=all-ones, found_ready=1 -> found nonces 0x100..0x107 in order, match_count=8, done after 8th transfer-in.
REQ-035 SHALL cover: target=0x10, hash index 3 top field=0x0F, others 0x10 -> exactly one found_nonce=base+3, match_count=1.
REQ-036 SHALL cover: all match, found_ready=0, FIFO_DEPTH=4 -> ready drops after 4 transfer-ins; releasing found_ready resumes with no loss or duplication.
REQ-037 SHALL cover: base_nonce=0xFFFFFFFE, all match -> nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, ...
REQ-038 SHALL cover: reset asserted after 3 transfer-ins with 2 nonces buffered -> found_valid=0, match_count=0, done=0; next job restarts at base_nonce.
